// File: rtl/operand_fetch.sv
// Operand fetch stage: 8-entry register file, serial A/B reads, 1-bit shifter on B,
// registered Ain/Bin under valid/ready. Optional write-through forwarding: OPERAND_FETCH_FWD_EN.
//
// state | meaning
// IDLE  | ready for a request; latches request fields on req_valid
// RD_A  | read port on rn; A operand captured into a_reg
// RD_B  | read port on rm; Ain/Bin loaded
// VALID | operands presented; wait for out_ready
module operand_fetch #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [1:0]    shift,
  input  logic [DW-1:0] sximm,
  input  logic          asel,
  input  logic          bsel,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, VALID} state_t;

  state_t        state;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] rn_q, rm_q;
  logic [1:0]    shift_q;
  logic [DW-1:0] sximm_q;
  logic          asel_q, bsel_q;
  logic [DW-1:0] a_reg;

  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  function automatic logic [DW-1:0] shift1(input logic [DW-1:0] x, input logic [1:0] op);
    case (op)
      2'b01:   shift1 = {x[DW-2:0], 1'b0};
      2'b10:   shift1 = {1'b0, x[DW-1:1]};
      2'b11:   shift1 = {x[DW-1], x[DW-1:1]};
      default: shift1 = x;
    endcase
  endfunction

  // Single read port, steered by which operand is being fetched this cycle.
  always_comb begin
    rd_idx  = (state == RD_B) ? rm_q : rn_q;
    rd_data = regs[rd_idx];
`ifdef OPERAND_FETCH_FWD_EN
    if (write && (writenum == rd_idx))
      rd_data = data_in;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      Ain       <= '0;
      Bin       <= '0;
      a_reg     <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= '0;
      sximm_q   <= '0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rn_q      <= rn;
            rm_q      <= rm;
            shift_q   <= shift;
            sximm_q   <= sximm;
            asel_q    <= asel;
            bsel_q    <= bsel;
            req_ready <= 1'b0;
            state     <= RD_A;
          end
        end
        RD_A: begin
          a_reg <= asel_q ? '0 : rd_data;
          state <= RD_B;
        end
        RD_B: begin
          Ain       <= a_reg;
          Bin       <= bsel_q ? sximm_q : shift1(rd_data, shift_q);
          out_valid <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
